div_sched: RTL and testbench

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_sched.sv | 97 +++++++++
 tb/tb_div_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// Programmable clock divider: registered clk_out/tick with glitch-free ratio
// changes that take effect only at a period boundary.
module div_sched #(
  parameter int W       = 8,
  parameter int DEF_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         clk_out,
  output logic         tick,
  output logic         busy,
  output logic [W-1:0] cur_div
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t       state, nxt_state;
  logic [W-1:0] cnt, nxt_cnt;
  logic [W-1:0] pend_div, nxt_pend;
  logic [W-1:0] nxt_div;
  logic         nxt_err;
  logic         hs, hs_ok, wrap, nxt_busy;

  assign cfg_ready = (state != PEND);
  assign busy      = (state != IDLE);
  assign hs        = cfg_valid && cfg_ready;
  assign hs_ok     = hs && (cfg_div >= W'(2));
  assign wrap      = (cnt == cur_div - W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_div   = cur_div;
    nxt_pend  = pend_div;
    nxt_err   = hs && !hs_ok;
    case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (hs_ok) nxt_div = cfg_div;
        if (en) nxt_state = RUN;
      end
      RUN: begin
        nxt_cnt = wrap ? '0 : cnt + W'(1);
        // A ratio accepted on a stopping wrap has no period left to wait for.
        if (hs_ok && wrap && !en) begin
          nxt_div   = cfg_div;
          nxt_state = IDLE;
        end else if (hs_ok) begin
          nxt_pend  = cfg_div;
          nxt_state = PEND;
        end else if (wrap && !en) begin
          nxt_state = IDLE;
        end
      end
      PEND: begin
        nxt_cnt = wrap ? '0 : cnt + W'(1);
        if (wrap) begin
          nxt_div   = pend_div;
          nxt_state = en ? RUN : IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign nxt_busy = (nxt_state != IDLE);

  // Outputs are computed from next-state values so they are true flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      cur_div  <= W'(DEF_DIV);
      pend_div <= '0;
      cfg_err  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      cnt      <= nxt_cnt;
      cur_div  <= nxt_div;
      pend_div <= nxt_pend;
      cfg_err  <= nxt_err;
      clk_out  <= nxt_busy && (nxt_cnt < (nxt_div >> 1));
      tick     <= nxt_busy && (nxt_cnt == '0);
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Scenario bench for div_sched: expected per-cycle output vectors are queued
// from the intended waveform and popped as each clock edge is observed.
module tb_div_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, en, cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready, cfg_err, clk_out, tick, busy;
  logic [W-1:0] cur_div;

  // {clk_out, tick, busy, cfg_ready, cfg_err, cur_div}
  logic [W+4:0] sb[$];
  int           total = 0;
  int           passed = 0;

  div_sched #(.W(W), .DEF_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick),
    .busy(busy), .cur_div(cur_div)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(bit co, bit tk, bit bs, bit rd, bit er, int dv);
    sb.push_back({co, tk, bs, rd, er, W'(dv)});
  endfunction

  // One expected divided-clock waveform: high for floor(n/2) of n cycles.
  function automatic void push_pat(int n, int periods, int dv);
    for (int p = 0; p < periods; p++)
      for (int c = 0; c < n; c++)
        push(c < n / 2, c == 0, 1'b1, 1'b1, 1'b0, dv);
  endfunction

  task automatic test_reset();
    logic [W+4:0] act;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    step(); step();
    rst = 1'b0;
    act = {clk_out, tick, busy, cfg_ready, cfg_err, cur_div};
    total++;
    if (act !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(4)})
      $display("FAIL reset_state got=%h exp=%h", act, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(4)});
    else passed++;
  endtask

  task automatic test_run4();
    logic [W+4:0] act, e;
    int i = 0;
    en = 1'b1;
    push_pat(4, 2, 4);
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      act = {clk_out, tick, busy, cfg_ready, cfg_err, cur_div};
      total++;
      if (act !== e) $display("FAIL run4 cyc%0d got=%h exp=%h", i, act, e);
      else passed++;
      i++;
    end
  endtask

  task automatic test_cfg_err();
    logic [W+4:0] act, e;
    int i = 0;
    cfg_valid = 1'b1; cfg_div = 8'd1;
    push(1, 1, 1, 1, 1, 4);
    push(1, 0, 1, 1, 0, 4);
    push(0, 0, 1, 1, 0, 4);
    push(0, 0, 1, 1, 0, 4);
    push_pat(4, 1, 4);
    while (sb.size() > 0) begin
      step();
      if (i == 0) cfg_valid = 1'b0;
      e = sb.pop_front();
      act = {clk_out, tick, busy, cfg_ready, cfg_err, cur_div};
      total++;
      if (act !== e) $display("FAIL cfg_err cyc%0d got=%h exp=%h", i, act, e);
      else passed++;
      i++;
    end
  endtask

  task automatic test_ratio_change();
    logic [W+4:0] act, e;
    int i = 0;
    push(1, 1, 1, 1, 0, 4);
    push(1, 0, 1, 1, 0, 4);
    push(0, 0, 1, 0, 0, 4);
    push(0, 0, 1, 0, 0, 4);
    push_pat(6, 2, 6);
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      act = {clk_out, tick, busy, cfg_ready, cfg_err, cur_div};
      total++;
      if (act !== e) $display("FAIL ratio_change cyc%0d got=%h exp=%h", i, act, e);
      else passed++;
      if (i == 1) begin cfg_valid = 1'b1; cfg_div = 8'd6; end
      if (i == 2) cfg_valid = 1'b0;
      i++;
    end
  endtask

  task automatic test_idle_ratios();
    logic [W+4:0] act, e;
    int i = 0;
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0; cfg_valid = 1'b1; cfg_div = 8'd3;
    push(0, 0, 0, 1, 0, 3);
    push_pat(3, 2, 3);
    push(0, 0, 0, 1, 0, 3);
    push(0, 0, 0, 1, 0, 2);
    push_pat(2, 3, 2);
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      act = {clk_out, tick, busy, cfg_ready, cfg_err, cur_div};
      total++;
      if (act !== e) $display("FAIL idle_ratios cyc%0d got=%h exp=%h", i, act, e);
      else passed++;
      if (i == 0) begin cfg_valid = 1'b0; en = 1'b1; end
      if (i == 6) en = 1'b0;
      if (i == 7) begin cfg_valid = 1'b1; cfg_div = 8'd2; end
      if (i == 8) begin cfg_valid = 1'b0; en = 1'b1; end
      i++;
    end
  endtask

  task automatic test_stop();
    logic [W+4:0] act, e;
    int i = 0;
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0; en = 1'b1;
    push_pat(4, 2, 4);
    push(1, 1, 1, 1, 0, 4);
    push(1, 0, 1, 1, 0, 4);
    push(0, 0, 1, 1, 0, 4);
    push(0, 0, 1, 1, 0, 4);
    push(0, 0, 0, 1, 0, 4);
    push(0, 0, 0, 1, 0, 4);
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      act = {clk_out, tick, busy, cfg_ready, cfg_err, cur_div};
      total++;
      if (act !== e) $display("FAIL stop cyc%0d got=%h exp=%h", i, act, e);
      else passed++;
      if (i == 5) en = 1'b0;
      if (i == 6) en = 1'b1;
      if (i == 8) en = 1'b0;
      i++;
    end
  endtask

  task automatic test_rst_pend();
    logic [W+4:0] act, e;
    int i = 0;
    en = 1'b1;
    push(1, 1, 1, 1, 0, 4);
    push(1, 0, 1, 1, 0, 4);
    push(0, 0, 1, 0, 0, 4);
    push(0, 0, 0, 1, 0, 4);
    push_pat(4, 2, 4);
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      act = {clk_out, tick, busy, cfg_ready, cfg_err, cur_div};
      total++;
      if (act !== e) $display("FAIL rst_pend cyc%0d got=%h exp=%h", i, act, e);
      else passed++;
      if (i == 1) begin cfg_valid = 1'b1; cfg_div = 8'd6; end
      if (i == 2) begin cfg_valid = 1'b0; rst = 1'b1; end
      if (i == 3) rst = 1'b0;
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_run4();
    test_cfg_err();
    test_ratio_change();
    test_idle_ratios();
    test_stop();
    test_rst_pend();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
